// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: tracking-slot layout and
// constants that must agree with the branch predictor.
package branch_resolver_pkg;

   localparam int TABLE_BITS_DEFAULT = 7;
   localparam int CNT_W_DEFAULT = 32;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef struct packed {
      logic        valid;
      logic        pred;
      logic        backward;
      logic [31:0] pc;
      logic [31:0] target;
   } slot_t;

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Saturating event counter used for branch statistics; sticks at all-ones
// instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Follows conditional branches from ID to MEM, resolves them against the real
// outcome, raises a flush with the corrected PC and trains the predictor.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int TABLE_BITS = TABLE_BITS_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  id_branch,
   input  logic                  id_pred_taken,
   input  logic                  id_backward,
   input  logic [31:0]           id_pc,
   input  logic [31:0]           id_target,
   input  logic                  mem_actual_taken,
   output logic                  flush,
   output logic [31:0]           redirect_pc,
   output logic                  upd_valid,
   output logic [TABLE_BITS-1:0] upd_idx,
   output logic                  upd_taken,
   output logic                  upd_backward,
   output logic [CNT_W-1:0]      br_count,
   output logic [CNT_W-1:0]      mispred_count
);

   slot_t ex_slot;
   slot_t mem_slot;
   logic  retire;

   always_comb begin
      flush       = mem_slot.valid && (mem_actual_taken != mem_slot.pred);
      redirect_pc = '0;
      if (flush) begin
         redirect_pc = mem_actual_taken ? mem_slot.target : (mem_slot.pc + PC_INC);
      end
   end

   assign retire = !stall && mem_slot.valid;

   // A flush empties both slots: the EX branch and the ID branch are wrong-path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_slot  <= '0;
         mem_slot <= '0;
      end else if (!stall) begin
         if (flush) begin
            ex_slot  <= '0;
            mem_slot <= '0;
         end else begin
            ex_slot  <= '{valid:    id_branch,
                         pred:     id_pred_taken,
                         backward: id_backward,
                         pc:       id_pc,
                         target:   id_target};
            mem_slot <= ex_slot;
         end
      end
   end

   // Every retiring branch trains the predictor exactly once, mispredicted or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_valid    <= 1'b0;
         upd_idx      <= '0;
         upd_taken    <= 1'b0;
         upd_backward <= 1'b0;
      end else if (retire) begin
         upd_valid    <= 1'b1;
         upd_idx      <= mem_slot.pc[TABLE_BITS+1:2];
         upd_taken    <= mem_actual_taken;
         upd_backward <= mem_slot.backward;
      end else begin
         upd_valid    <= 1'b0;
      end
   end

   sat_counter #(.W(CNT_W)) u_br_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire),
      .count (br_count)
   );

   sat_counter #(.W(CNT_W)) u_mispred_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire && flush),
      .count (mispred_count)
   );

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized scoreboard bench for branch_resolver: a transaction-level model
// predicts flushes and predictor updates, a monitor compares retirements.
module tb_branch_resolver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        id_branch = 1'b0;
   logic        id_pred_taken = 1'b0;
   logic        id_backward = 1'b0;
   logic [31:0] id_pc = '0;
   logic [31:0] id_target = '0;
   logic        mem_actual_taken = 1'b0;

   logic        flush;
   logic [31:0] redirect_pc;
   logic        upd_valid;
   logic [6:0]  upd_idx;
   logic        upd_taken;
   logic        upd_backward;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   logic        flush4;
   logic [31:0] redirect_pc4;
   logic        upd_valid4;
   logic [6:0]  upd_idx4;
   logic        upd_taken4;
   logic        upd_backward4;
   logic [3:0]  br_count4;
   logic [3:0]  mispred_count4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          pred;
      bit          bw;
      bit          act;
      logic [31:0] pc;
      logic [31:0] tg;
      int          age;
   } rec_t;

   typedef struct {
      logic [6:0] idx;
      bit         taken;
      bit         bw;
      longint     br;
      longint     mis;
   } exp_t;

   rec_t   infl[$];
   exp_t   exp_q[$];
   longint nbr = 0;
   longint nmis = 0;
   logic [6:0] last_idx = '0;
   bit     last_taken = 1'b0;
   bit     last_bw = 1'b0;

   branch_resolver dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .id_branch(id_branch),
      .id_pred_taken(id_pred_taken), .id_backward(id_backward), .id_pc(id_pc),
      .id_target(id_target), .mem_actual_taken(mem_actual_taken),
      .flush(flush), .redirect_pc(redirect_pc), .upd_valid(upd_valid),
      .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_backward(upd_backward),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   branch_resolver #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .id_branch(id_branch),
      .id_pred_taken(id_pred_taken), .id_backward(id_backward), .id_pc(id_pc),
      .id_target(id_target), .mem_actual_taken(mem_actual_taken),
      .flush(flush4), .redirect_pc(redirect_pc4), .upd_valid(upd_valid4),
      .upd_idx(upd_idx4), .upd_taken(upd_taken4), .upd_backward(upd_backward4),
      .br_count(br_count4), .mispred_count(mispred_count4)
   );

   always #5 clk = ~clk;

   function automatic longint sat(input longint v, input longint maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input bit exp_fl, input logic [31:0] exp_rd);
      checkValue("flush", 64'(flush), 64'(exp_fl));
      checkValue("redirect_pc", 64'(redirect_pc), 64'(exp_rd));
      checkValue("flush_cnt4", 64'(flush4), 64'(exp_fl));
   endtask

   // One cycle: drive at posedge+1, check resolution mid-cycle, advance the model on the edge.
   task automatic applyStimulus(input bit br, input bit pr, input bit bw,
                                input logic [31:0] pc, input logic [31:0] tg,
                                input bit act, input bit st);
      bit          in_mem;
      bit          exp_fl;
      logic [31:0] exp_rd;
      rec_t        m;
      in_mem = (infl.size() > 0) && (infl[0].age == 2);
      stall = st;
      id_branch = br;
      id_pred_taken = pr;
      id_backward = bw;
      id_pc = pc;
      id_target = tg;
      mem_actual_taken = in_mem ? infl[0].act : 1'($urandom);
      exp_fl = in_mem && (infl[0].act != infl[0].pred);
      exp_rd = '0;
      if (exp_fl) exp_rd = infl[0].act ? infl[0].tg : infl[0].pc + 32'd4;
      @(negedge clk);
      checkOutput(exp_fl, exp_rd);
      @(posedge clk);
      if (!st) begin
         if (in_mem) begin
            m = infl.pop_front();
            nbr++;
            if (exp_fl) nmis++;
            exp_q.push_back('{idx: m.pc[8:2], taken: m.act, bw: m.bw, br: nbr, mis: nmis});
         end
         if (exp_fl) infl.delete();
         foreach (infl[i]) infl[i].age++;
         if (br && !exp_fl) infl.push_back('{pred: pr, bw: bw, act: act, pc: pc, tg: tg, age: 1});
      end
      #1;
   endtask

   task automatic idleCycle(input bit st);
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, 1'b0, st);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      infl.delete();
      exp_q.delete();
      nbr = 0;
      nmis = 0;
      last_idx = '0;
      last_taken = 1'b0;
      last_bw = 1'b0;
      #1;
      checkValue("rst_flush", 64'(flush), 64'd0);
      checkValue("rst_redirect", 64'(redirect_pc), 64'd0);
      checkValue("rst_upd_valid", 64'(upd_valid), 64'd0);
      checkValue("rst_upd_idx", 64'(upd_idx), 64'd0);
      checkValue("rst_upd_taken", 64'(upd_taken), 64'd0);
      checkValue("rst_upd_backward", 64'(upd_backward), 64'd0);
      checkValue("rst_br_count", 64'(br_count), 64'd0);
      checkValue("rst_mispred_count", 64'(mispred_count), 64'd0);
      checkValue("rst_br_count4", 64'(br_count4), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every update pulse must match the oldest predicted retirement.
   always @(negedge clk) begin
      exp_t e;
      if (upd_valid) begin
         if (exp_q.size() == 0) begin
            checkValue("unexpected_upd_valid", 64'(upd_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            checkValue("upd_idx", 64'(upd_idx), 64'(e.idx));
            checkValue("upd_taken", 64'(upd_taken), 64'(e.taken));
            checkValue("upd_backward", 64'(upd_backward), 64'(e.bw));
            checkValue("br_count", 64'(br_count), 64'(sat(e.br, 64'hFFFF_FFFF)));
            checkValue("mispred_count", 64'(mispred_count), 64'(sat(e.mis, 64'hFFFF_FFFF)));
            checkValue("br_count4", 64'(br_count4), 64'(sat(e.br, 15)));
            checkValue("mispred_count4", 64'(mispred_count4), 64'(sat(e.mis, 15)));
            last_idx = e.idx;
            last_taken = e.taken;
            last_bw = e.bw;
         end
      end else begin
         if (exp_q.size() != 0) begin
            checkValue("missing_upd_valid", 64'(upd_valid), 64'd1);
            void'(exp_q.pop_front());
         end
         checkValue("upd_idx_hold", 64'(upd_idx), 64'(last_idx));
         checkValue("upd_taken_hold", 64'(upd_taken), 64'(last_taken));
         checkValue("upd_backward_hold", 64'(upd_backward), 64'(last_bw));
      end
   end

   initial begin
      #1;
      doReset();

      // correct taken prediction
      applyStimulus(1, 1, 1, 32'h100, 32'h80, 1, 0);
      repeat (3) idleCycle(0);
      // not-taken mispredict
      applyStimulus(1, 1, 0, 32'h200, 32'h240, 0, 0);
      repeat (3) idleCycle(0);
      // taken mispredict kills the younger branch in EX
      applyStimulus(1, 0, 0, 32'h280, 32'h300, 1, 0);
      applyStimulus(1, 1, 0, 32'h400, 32'h500, 1, 0);
      repeat (3) idleCycle(0);
      // mispredict held in MEM across a three-cycle stall
      applyStimulus(1, 1, 0, 32'h500, 32'h600, 0, 0);
      idleCycle(0);
      repeat (3) idleCycle(1);
      repeat (3) idleCycle(0);
      // fall-through address wraps past the top of memory
      applyStimulus(1, 1, 0, 32'hFFFF_FFFC, 32'h10, 0, 0);
      repeat (3) idleCycle(0);
      // reset with both slots occupied
      applyStimulus(1, 1, 0, 32'h700, 32'h800, 1, 0);
      applyStimulus(1, 0, 1, 32'h704, 32'h600, 0, 0);
      doReset();
      repeat (3) idleCycle(0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            doReset();
         end else begin
            applyStimulus(($urandom_range(0, 9) < 6), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                          $urandom & 32'hFFFF_FFFC, 1'($urandom),
                          ($urandom_range(0, 4) == 0));
         end
      end
      repeat (4) idleCycle(0);
      checkValue("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Tracks every decoded conditional branch from ID through EX to MEM alongside its prediction, resolves it against the actual outcome in MEM, and raises a one-cycle pipeline flush with a corrected fetch PC on a mispredict. It is the consumer/trainer end of the branch-prediction path: it takes the predictor's ID-stage outputs and returns a registered per-PC update message to the pattern table. It also keeps saturating branch and mispredict statistics.

## Interface
- TABLE_BITS, 7, predictor index width; index = pc[TABLE_BITS+1:2]
- CNT_W, 32, width of each statistics counter
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline hold; tracking slots and counters freeze
- id_branch  in  1  conditional branch in ID this cycle
- id_pred_taken  in  1  predictor decision for that branch
- id_backward  in  1  branch offset sign bit (1 = backward)
- id_pc  in  32  PC of the branch
- id_target  in  32  taken target (pc + offset)
- mem_actual_taken  in  1  resolved condition for the branch now in MEM
- flush  out  1  mispredict; kill IF/ID/EX contents, load redirect_pc
- redirect_pc  out  32  corrected fetch address, valid while flush = 1
- upd_valid  out  1  one-cycle predictor update strobe
- upd_idx  out  TABLE_BITS  table entry to train
- upd_taken  out  1  actual outcome
- upd_backward  out  1  backward flag of the retired branch
- br_count  out  CNT_W  retired branches, saturating
- mispred_count  out  CNT_W  mispredicts, saturating

## Operation
- Two tracking slots, ex_slot and mem_slot, each {valid, pred, backward, pc, target}.
- Posedge, stall = 0, flush = 0: ex_slot ← ID inputs with valid = id_branch; mem_slot ← ex_slot.
- Posedge, stall = 0, flush = 1: both slots invalidated. The ID inputs that cycle are wrong-path and are discarded.
- Posedge, stall = 1: slots, update outputs and counters hold. upd_valid is driven 0.
- Resolution is combinational from mem_slot:
  - flush = mem_slot.valid & (mem_actual_taken ≠ mem_slot.pred).
  - redirect_pc = mem_actual_taken ? mem_slot.target : mem_slot.pc + 4, modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
  - When flush = 0, redirect_pc = 0.
- Update: on a posedge with stall = 0 and mem_slot.valid:
  - upd_valid ← 1, upd_idx ← mem_slot.pc[TABLE_BITS+1:2], upd_taken ← mem_actual_taken, upd_backward ← mem_slot.backward.
  - Otherwise upd_valid ← 0, and the other upd fields hold.
- Updates are issued for backward branches too; filtering them is the predictor's choice.
- Counters, on the same retiring edge: br_count += 1; mispred_count += 1 if flush. Both saturate at 2^CNT_W−1 and never wrap.
- A flushed branch still retires: it produces exactly one update and counts once.

## Timing
- Reset (async assert, any cycle, mid-flight included): slots invalid, flush = 0, redirect_pc = 0, upd_valid = 0, upd_idx = 0, upd_taken = 0, upd_backward = 0, both counters = 0. Deassertion takes effect at the next posedge.
- Branch in ID at edge-cycle t → occupies MEM during t+2 → flush/redirect is combinational in t+2 → upd_valid is high in t+3.
- A stall while a mispredict sits in MEM holds flush and redirect_pc high and stable until the first non-stalled posedge, then flush drops.
- Back-to-back branches are supported: both slots valid simultaneously. A mispredict in MEM kills the younger branch in EX, and that younger branch produces no update.
- Simultaneous id_branch and flush: the ID branch is dropped.

## Structure
- Shared defines header: slot field layout, PC increment constant 4, default TABLE_BITS shared with the predictor.
- One sub-module is natural: sat_counter (parameter W; inputs clk, rst_n, inc; output count), instantiated twice for the statistics.
- Expected size: about 150–250 lines of RTL.

## Test plan
- Correct prediction: id_branch = 1, pred = 1, pc = 0x100, target = 0x80, actual = 1 → flush stays 0; upd_valid in t+3 with upd_idx = 0x40, upd_taken = 1; br_count = 1, mispred_count = 0.
- Not-taken mispredict: pred = 1, pc = 0x200, actual = 0 → flush = 1 in t+2, redirect_pc = 0x204; mispred_count = 1.
- Taken mispredict with younger branch in EX: pred = 0, target = 0x300, actual = 1 → redirect_pc = 0x300. The EX-slot branch yields no upd_valid, and br_count increments only once.
- Stall for 3 cycles with a mispredict in MEM → flush is held for 4 cycles; exactly one upd_valid pulse; counters increment once.
- PC wrap: pc = 0xFFFFFFFC, pred = 1, actual = 0 → redirect_pc = 0x00000000. Separately, preload counters near saturation (CNT_W = 4, 16 retirements) → br_count stays at 15.
- rst_n asserted while both slots are valid → all outputs return to reset values immediately, with no update pulse after release.
